// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: datapath widths,
// the arbitration mode and the registered write command.
package regfile_write_arbiter_pkg;

  localparam int RegAddrWidth = 5;
  localparam int DataWidth    = 32;
  localparam logic [RegAddrWidth-1:0] ZeroReg = 5'd0;

  typedef enum logic {
    ArbNormal,
    ArbStarved
  } arbState_e;

  typedef struct packed {
    logic                    regWrite;
    logic [RegAddrWidth-1:0] writeRegister;
    logic [DataWidth-1:0]    writeData;
  } writeCmd_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writeback request ports and the RegisterFile write port.
// The master side is the requesters/register file, the slave side the arbiter.
interface regfile_write_arbiter_if;
  import regfile_write_arbiter_pkg::*;

  logic                    Valid0;
  logic [RegAddrWidth-1:0] Reg0;
  logic [DataWidth-1:0]    Data0;
  logic                    Ready0;

  logic                    Valid1;
  logic [RegAddrWidth-1:0] Reg1;
  logic [DataWidth-1:0]    Data1;
  logic                    Ready1;

  logic                    RegWrite;
  logic [RegAddrWidth-1:0] WriteRegister;
  logic [DataWidth-1:0]    WriteData;

  modport master (
    output Valid0, Reg0, Data0, Valid1, Reg1, Data1,
    input  Ready0, Ready1, RegWrite, WriteRegister, WriteData
  );

  modport slave (
    input  Valid0, Reg0, Data0, Valid1, Reg1, Data1,
    output Ready0, Ready1, RegWrite, WriteRegister, WriteData
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the RegisterFile write port between the pipeline writeback (port 0,
// fixed priority) and the multi-cycle unit (port 1, bounded starvation).
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int MaxWait = 3
) (
  input  logic                    Clk,
  input  logic                    Reset,
  regfile_write_arbiter_if.slave  bus,
  output logic                    Starved
);

  localparam int CntW = $clog2(MaxWait + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxWait);

  logic [CntW-1:0] waitCnt_q, waitCnt_d;
  writeCmd_t       cmd_q, cmd_d;
  arbState_e       state;
  logic            xfer0, xfer1;

  // Port 1 gains priority once it has been refused MaxWait cycles in a row.
  assign state = (waitCnt_q == MaxCnt) ? ArbStarved : ArbNormal;

  always_comb begin
    bus.Ready0 = 1'b0;
    bus.Ready1 = 1'b0;
    if (!Reset) begin
      case (state)
        ArbNormal: begin
          bus.Ready0 = 1'b1;
          bus.Ready1 = !bus.Valid0;
        end
        ArbStarved: begin
          bus.Ready0 = !bus.Valid1;
          bus.Ready1 = 1'b1;
        end
        default: begin
          bus.Ready0 = 1'b0;
          bus.Ready1 = 1'b0;
        end
      endcase
    end
  end

  assign xfer0 = bus.Valid0 && bus.Ready0;
  assign xfer1 = bus.Valid1 && bus.Ready1;

  always_comb begin
    waitCnt_d = waitCnt_q;
    if (!bus.Valid1 || xfer1) begin
      waitCnt_d = '0;
    end else if (waitCnt_q != MaxCnt) begin
      waitCnt_d = waitCnt_q + CntW'(1);
    end
  end

  // Idle cycles keep the last address/data and only drop RegWrite;
  // $0 is accepted as a transfer but never raises RegWrite.
  always_comb begin
    cmd_d          = cmd_q;
    cmd_d.regWrite = 1'b0;
    if (xfer0) begin
      cmd_d.regWrite      = (bus.Reg0 != ZeroReg);
      cmd_d.writeRegister = bus.Reg0;
      cmd_d.writeData     = bus.Data0;
    end else if (xfer1) begin
      cmd_d.regWrite      = (bus.Reg1 != ZeroReg);
      cmd_d.writeRegister = bus.Reg1;
      cmd_d.writeData     = bus.Data1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      waitCnt_q <= '0;
      cmd_q     <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
      cmd_q     <= cmd_d;
    end
  end

  assign bus.RegWrite      = cmd_q.regWrite;
  assign bus.WriteRegister = cmd_q.writeRegister;
  assign bus.WriteData     = cmd_q.writeData;
  assign Starved           = (state == ArbStarved);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: a register-file stand-in fed by the arbiter,
// a per-cycle reference model of the arbitration rules, and directed scenarios.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int MaxWait = 3;

  logic Clk;
  logic Reset;
  logic Starved;
  int   checks = 0;
  int   errors = 0;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.MaxWait(MaxWait)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .bus     (bus),
    .Starved (Starved)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file driven by the arbiter's write port; $0 reads as zero.
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  always @(posedge Clk) if (bus.RegWrite && bus.WriteRegister != 5'd0) rf[bus.WriteRegister] <= bus.WriteData;

  function automatic logic [31:0] readRegister(input logic [4:0] addr);
    return (addr == 5'd0) ? 32'h0 : rf[addr];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    bus.Valid0 = v0; bus.Reg0 = r0; bus.Data0 = d0;
    bus.Valid1 = v1; bus.Reg1 = r1; bus.Data1 = d1;
  endtask

  // Reference model: refusal count of port 1 and the command the register
  // file should see, checked against the DUT between clock edges.
  int          refused;
  logic        mRegWrite;
  logic [4:0]  mReg;
  logic [31:0] mData;

  initial begin
    logic prio, eR0, eR1, win0, win1, rst, v1;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;
    refused = 0; mRegWrite = 1'b0; mReg = 5'd0; mData = 32'h0;
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      rst  = Reset;
      prio = (refused >= MaxWait);
      eR0  = !rst && (!prio || !bus.Valid1);
      eR1  = !rst && (prio || !bus.Valid0);
      checkOutput("model Ready0", {31'b0, bus.Ready0}, {31'b0, eR0});
      checkOutput("model Ready1", {31'b0, bus.Ready1}, {31'b0, eR1});
      checkOutput("model Starved", {31'b0, Starved}, {31'b0, prio});
      checkOutput("model RegWrite", {31'b0, bus.RegWrite}, {31'b0, mRegWrite});
      checkOutput("model WriteRegister", {27'b0, bus.WriteRegister}, {27'b0, mReg});
      checkOutput("model WriteData", bus.WriteData, mData);
      win0 = bus.Valid0 && eR0;
      win1 = bus.Valid1 && eR1;
      v1 = bus.Valid1;
      r0 = bus.Reg0; d0 = bus.Data0; r1 = bus.Reg1; d1 = bus.Data1;
      @(posedge Clk);
      if (rst) begin
        refused = 0; mRegWrite = 1'b0; mReg = 5'd0; mData = 32'h0;
      end else begin
        if (win0) begin
          mRegWrite = (r0 != 5'd0); mReg = r0; mData = d0;
        end else if (win1) begin
          mRegWrite = (r1 != 5'd0); mReg = r1; mData = d1;
        end else begin
          mRegWrite = 1'b0;
        end
        if (v1 && !win1) refused = (refused < MaxWait) ? refused + 1 : MaxWait;
        else refused = 0;
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 50000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h77, 1'b1, 5'd4, 32'h88);

    // Reset with both ports requesting: nothing accepted, outputs cleared.
    repeat (2) begin
      @(posedge Clk);
      @(negedge Clk);
      checkOutput("reset Ready0", {31'b0, bus.Ready0}, 32'd0);
      checkOutput("reset Ready1", {31'b0, bus.Ready1}, 32'd0);
      checkOutput("reset RegWrite", {31'b0, bus.RegWrite}, 32'd0);
      checkOutput("reset WriteRegister", {27'b0, bus.WriteRegister}, 32'd0);
      checkOutput("reset WriteData", bus.WriteData, 32'd0);
    end
    step();
    Reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Single port-0 write.
    step();
    applyStimulus(1'b1, 5'd8, 32'h1234, 1'b0, 5'd0, 32'h0);
    @(negedge Clk);
    checkOutput("single Ready0", {31'b0, bus.Ready0}, 32'd1);
    step();
    bus.Valid0 = 1'b0;
    @(negedge Clk);
    checkOutput("single RegWrite", {31'b0, bus.RegWrite}, 32'd1);
    checkOutput("single WriteRegister", {27'b0, bus.WriteRegister}, 32'd8);
    step();
    @(negedge Clk);
    checkOutput("single read $8", readRegister(5'd8), 32'h1234);

    // Both valid without starvation: port 0 first, port 1 on the next edge.
    step();
    applyStimulus(1'b1, 5'd9, 32'hA, 1'b1, 5'd10, 32'hB);
    @(negedge Clk);
    checkOutput("both Ready1 refused", {31'b0, bus.Ready1}, 32'd0);
    step();
    bus.Valid0 = 1'b0;
    @(negedge Clk);
    checkOutput("both first WriteRegister", {27'b0, bus.WriteRegister}, 32'd9);
    checkOutput("both Ready1 accepted", {31'b0, bus.Ready1}, 32'd1);
    step();
    bus.Valid1 = 1'b0;
    @(negedge Clk);
    checkOutput("both second WriteRegister", {27'b0, bus.WriteRegister}, 32'd10);
    checkOutput("both second WriteData", bus.WriteData, 32'hB);
    step();
    @(negedge Clk);
    checkOutput("both read $9", readRegister(5'd9), 32'hA);
    checkOutput("both read $10", readRegister(5'd10), 32'hB);

    // Starvation: port 0 never idles, port 1 must still get through.
    step();
    applyStimulus(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'hC);
    for (int i = 0; i < MaxWait; i++) begin
      @(negedge Clk);
      checkOutput("starve Ready1 refused", {31'b0, bus.Ready1}, 32'd0);
      checkOutput("starve Starved low", {31'b0, Starved}, 32'd0);
      step();
    end
    @(negedge Clk);
    checkOutput("starve Starved high", {31'b0, Starved}, 32'd1);
    checkOutput("starve Ready1 granted", {31'b0, bus.Ready1}, 32'd1);
    checkOutput("starve Ready0 stalled", {31'b0, bus.Ready0}, 32'd0);
    step();
    bus.Valid1 = 1'b0;
    @(negedge Clk);
    checkOutput("starve cleared", {31'b0, Starved}, 32'd0);
    checkOutput("starve WriteRegister", {27'b0, bus.WriteRegister}, 32'd12);
    checkOutput("starve WriteData", bus.WriteData, 32'hC);
    step();
    bus.Valid0 = 1'b0;
    step();
    @(negedge Clk);
    checkOutput("starve read $12", readRegister(5'd12), 32'hC);
    checkOutput("starve read $11", readRegister(5'd11), 32'h11);

    // Write to $0 is accepted but never reaches RegWrite.
    step();
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    @(negedge Clk);
    checkOutput("zero Ready0", {31'b0, bus.Ready0}, 32'd1);
    step();
    bus.Valid0 = 1'b0;
    @(negedge Clk);
    checkOutput("zero RegWrite", {31'b0, bus.RegWrite}, 32'd0);
    step();
    @(negedge Clk);
    checkOutput("zero read $0", readRegister(5'd0), 32'h0);

    // Same destination on both ports: two writes, port 1's data survives.
    step();
    applyStimulus(1'b1, 5'd13, 32'h1, 1'b1, 5'd13, 32'h2);
    step();
    bus.Valid0 = 1'b0;
    @(negedge Clk);
    checkOutput("same first WriteData", bus.WriteData, 32'h1);
    checkOutput("same first RegWrite", {31'b0, bus.RegWrite}, 32'd1);
    step();
    bus.Valid1 = 1'b0;
    @(negedge Clk);
    checkOutput("same second WriteData", bus.WriteData, 32'h2);
    checkOutput("same second WriteRegister", {27'b0, bus.WriteRegister}, 32'd13);
    step();
    @(negedge Clk);
    checkOutput("same read $13", readRegister(5'd13), 32'h2);

    // Reset mid-operation discards the pending request.
    step();
    Reset = 1'b1;
    applyStimulus(1'b1, 5'd14, 32'h5, 1'b0, 5'd0, 32'h0);
    @(negedge Clk);
    checkOutput("midreset Ready0", {31'b0, bus.Ready0}, 32'd0);
    step();
    Reset = 1'b0;
    bus.Valid0 = 1'b0;
    @(negedge Clk);
    checkOutput("midreset RegWrite", {31'b0, bus.RegWrite}, 32'd0);
    checkOutput("midreset WriteRegister", {27'b0, bus.WriteRegister}, 32'd0);
    step();
    step();
    @(negedge Clk);
    checkOutput("midreset read $14", readRegister(5'd14), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
